// File: rtl/uart_cmd_master.sv
// uart_cmd_master: host-side initiator for the UART register/ALU command
// protocol. Serialises one parallel command into a byte frame over a
// valid/ready byte port, then gathers the response bytes (or times out).
module uart_cmd_master #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_OUT_WIDTH = 16,
   parameter int TIMEOUT       = 4096
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     CMD_VLD,
   output logic                     CMD_RDY,
   input  logic [1:0]               CMD_TYPE,
   input  logic [ADDR_WIDTH-1:0]    CMD_ADDR,
   input  logic [DATA_WIDTH-1:0]    CMD_DATA,
   input  logic [DATA_WIDTH-1:0]    CMD_OPB,
   input  logic [3:0]               CMD_FUN,
   output logic [DATA_WIDTH-1:0]    TX_DATA,
   output logic                     TX_VLD,
   input  logic                     TX_RDY,
   input  logic [DATA_WIDTH-1:0]    RX_DATA,
   input  logic                     RX_VLD,
   output logic [ALU_OUT_WIDTH-1:0] RSP_DATA,
   output logic                     RSP_VLD,
   output logic                     RSP_TIMEOUT,
   output logic                     BUSY
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   state_t                   state_r;
   logic [1:0]               type_r;
   logic [ADDR_WIDTH-1:0]    addr_r;
   logic [DATA_WIDTH-1:0]    data_r;
   logic [DATA_WIDTH-1:0]    opb_r;
   logic [3:0]               fun_r;
   logic [1:0]               byte_idx_r;
   logic                     rx_cnt_r;
   logic [DATA_WIDTH-1:0]    rx_b0_r;
   logic [TW-1:0]            tmo_cnt_r;
   logic [DATA_WIDTH-1:0]    tx_data_r;
   logic                     tx_vld_r;
   logic [ALU_OUT_WIDTH-1:0] rsp_data_r;
   logic                     rsp_vld_r;
   logic                     rsp_timeout_r;
   logic                     busy_r;

   // Byte 'idx' of the frame for a command of type 't'.
   function automatic logic [DATA_WIDTH-1:0] frame_byte(
      input logic [1:0]            t,
      input logic [1:0]            idx,
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [DATA_WIDTH-1:0] data,
      input logic [DATA_WIDTH-1:0] opb,
      input logic [3:0]            fun
   );
      logic [DATA_WIDTH-1:0] b;
      b = {DATA_WIDTH{1'b0}};
      case (t)
         2'b00: begin
            case (idx)
               2'd0:    b = DATA_WIDTH'(8'hAA);
               2'd1:    b = DATA_WIDTH'(addr);
               2'd2:    b = data;
               default: b = {DATA_WIDTH{1'b0}};
            endcase
         end
         2'b01: begin
            case (idx)
               2'd0:    b = DATA_WIDTH'(8'hBB);
               2'd1:    b = DATA_WIDTH'(addr);
               default: b = {DATA_WIDTH{1'b0}};
            endcase
         end
         2'b10: begin
            case (idx)
               2'd0:    b = DATA_WIDTH'(8'hCC);
               2'd1:    b = data;
               2'd2:    b = opb;
               default: b = DATA_WIDTH'(fun);
            endcase
         end
         default: begin
            case (idx)
               2'd0:    b = DATA_WIDTH'(8'hDD);
               2'd1:    b = DATA_WIDTH'(fun);
               default: b = {DATA_WIDTH{1'b0}};
            endcase
         end
      endcase
      return b;
   endfunction

   // Index of the final frame byte for a command of type 't'.
   function automatic logic [1:0] last_idx(input logic [1:0] t);
      logic [1:0] r;
      case (t)
         2'b00:   r = 2'd2;
         2'b01:   r = 2'd1;
         2'b10:   r = 2'd3;
         default: r = 2'd1;
      endcase
      return r;
   endfunction

   // Command FSM: accept, stream frame bytes, collect response or time out.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r       <= IDLE;
         type_r        <= 2'b00;
         addr_r        <= {ADDR_WIDTH{1'b0}};
         data_r        <= {DATA_WIDTH{1'b0}};
         opb_r         <= {DATA_WIDTH{1'b0}};
         fun_r         <= 4'h0;
         byte_idx_r    <= 2'd0;
         rx_cnt_r      <= 1'b0;
         rx_b0_r       <= {DATA_WIDTH{1'b0}};
         tmo_cnt_r     <= {TW{1'b0}};
         tx_data_r     <= {DATA_WIDTH{1'b0}};
         tx_vld_r      <= 1'b0;
         rsp_data_r    <= {ALU_OUT_WIDTH{1'b0}};
         rsp_vld_r     <= 1'b0;
         rsp_timeout_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         rsp_vld_r     <= 1'b0;
         rsp_timeout_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (CMD_VLD) begin
                  type_r     <= CMD_TYPE;
                  addr_r     <= CMD_ADDR;
                  data_r     <= CMD_DATA;
                  opb_r      <= CMD_OPB;
                  fun_r      <= CMD_FUN;
                  byte_idx_r <= 2'd0;
                  tx_data_r  <= frame_byte(CMD_TYPE, 2'd0, CMD_ADDR, CMD_DATA, CMD_OPB, CMD_FUN);
                  tx_vld_r   <= 1'b1;
                  state_r    <= SEND;
                  busy_r     <= 1'b1;
               end
            end
            SEND: begin
               if (tx_vld_r && TX_RDY) begin
                  if (byte_idx_r == last_idx(type_r)) begin
                     tx_vld_r   <= 1'b0;
                     byte_idx_r <= 2'd0;
                     if (type_r == 2'b00) begin
                        // Writes have no response bytes: complete right away.
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                        rsp_vld_r  <= 1'b1;
                        rsp_data_r <= {ALU_OUT_WIDTH{1'b0}};
                     end else begin
                        state_r   <= WAIT_RSP;
                        rx_cnt_r  <= 1'b0;
                        tmo_cnt_r <= {TW{1'b0}};
                     end
                  end else begin
                     byte_idx_r <= byte_idx_r + 2'd1;
                     tx_data_r  <= frame_byte(type_r, byte_idx_r + 2'd1, addr_r, data_r, opb_r, fun_r);
                  end
               end
            end
            WAIT_RSP: begin
               if (RX_VLD) begin
                  // A received byte always beats an expiring timeout.
                  tmo_cnt_r <= {TW{1'b0}};
                  if ((type_r == 2'b01) || rx_cnt_r) begin
                     state_r   <= IDLE;
                     busy_r    <= 1'b0;
                     rsp_vld_r <= 1'b1;
                     rx_cnt_r  <= 1'b0;
                     if (type_r == 2'b01) begin
                        rsp_data_r <= {{(ALU_OUT_WIDTH-DATA_WIDTH){1'b0}}, RX_DATA};
                     end else begin
                        rsp_data_r <= ALU_OUT_WIDTH'({RX_DATA, rx_b0_r});
                     end
                  end else begin
                     rx_b0_r  <= RX_DATA;
                     rx_cnt_r <= 1'b1;
                  end
               end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
                  state_r       <= IDLE;
                  busy_r        <= 1'b0;
                  rsp_timeout_r <= 1'b1;
                  tmo_cnt_r     <= {TW{1'b0}};
                  rx_cnt_r      <= 1'b0;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
            end
            default: begin
               state_r  <= IDLE;
               busy_r   <= 1'b0;
               tx_vld_r <= 1'b0;
            end
         endcase
      end
   end

   assign CMD_RDY     = (state_r == IDLE);
   assign TX_DATA     = tx_data_r;
   assign TX_VLD      = tx_vld_r;
   assign RSP_DATA    = rsp_data_r;
   assign RSP_VLD     = rsp_vld_r;
   assign RSP_TIMEOUT = rsp_timeout_r;
   assign BUSY        = busy_r;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master: directed scenarios plus a
// randomised run, all compared against a byte-queue reference model.
module tb_uart_cmd_master;

   localparam int T = 64;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        CMD_VLD = 1'b0;
   logic        CMD_RDY;
   logic [1:0]  CMD_TYPE = 2'b00;
   logic [3:0]  CMD_ADDR = 4'h0;
   logic [7:0]  CMD_DATA = 8'h00;
   logic [7:0]  CMD_OPB = 8'h00;
   logic [3:0]  CMD_FUN = 4'h0;
   logic [7:0]  TX_DATA;
   logic        TX_VLD;
   logic        TX_RDY = 1'b0;
   logic [7:0]  RX_DATA = 8'h00;
   logic        RX_VLD = 1'b0;
   logic [15:0] RSP_DATA;
   logic        RSP_VLD;
   logic        RSP_TIMEOUT;
   logic        BUSY;

   uart_cmd_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16), .TIMEOUT(T)) dut (
      .CLK(CLK), .RST(RST), .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_TYPE(CMD_TYPE),
      .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN),
      .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_RDY(TX_RDY), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
      .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD), .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int n_pass = 0;
   int n_total = 0;

   // Monitor state (sampled on the falling edge)
   logic [7:0] tx_log[$];
   int         hold_viol = 0;
   int         rsp_cnt = 0;
   int         tmo_cnt = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // Reference model state
   logic [7:0]  exp_q[$];
   logic [15:0] last_rsp = 16'h0000;

   // Record handshaken bytes, stall-hold violations and response pulses.
   always @(negedge CLK) begin
      if (RST && prev_stall && (!TX_VLD || TX_DATA !== prev_data)) hold_viol++;
      prev_stall = TX_VLD && !TX_RDY && RST;
      prev_data  = TX_DATA;
      if (TX_VLD && TX_RDY) tx_log.push_back(TX_DATA);
      if (RSP_VLD) rsp_cnt++;
      if (RSP_TIMEOUT) tmo_cnt++;
   end

   // Watchdog so the run always ends.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic void model_frame(input logic [1:0] t, input logic [3:0] a,
                                       input logic [7:0] d, input logic [7:0] b, input logic [3:0] f);
      exp_q.delete();
      case (t)
         2'd0: begin exp_q.push_back(8'hAA); exp_q.push_back({4'h0, a}); exp_q.push_back(d); end
         2'd1: begin exp_q.push_back(8'hBB); exp_q.push_back({4'h0, a}); end
         2'd2: begin exp_q.push_back(8'hCC); exp_q.push_back(d); exp_q.push_back(b); exp_q.push_back({4'h0, f}); end
         default: begin exp_q.push_back(8'hDD); exp_q.push_back({4'h0, f}); end
      endcase
   endfunction

   function automatic int model_rsp_len(input logic [1:0] t);
      return (t == 2'd0) ? 0 : (t == 2'd1) ? 1 : 2;
   endfunction

   function automatic logic [15:0] model_rsp(input logic [1:0] t, input logic [7:0] b0, input logic [7:0] b1);
      int v;
      if (t == 2'd0) v = 0;
      else if (t == 2'd1) v = b0;
      else v = b1 * 256 + b0;
      return 16'(v);
   endfunction

   function automatic logic [39:0] pack_log();
      logic [39:0] r;
      r = 40'd0;
      r[39:32] = 8'(tx_log.size());
      foreach (tx_log[i]) if (i < 4) r[i*8 +: 8] = tx_log[i];
      return r;
   endfunction

   function automatic logic [39:0] pack_exp();
      logic [39:0] r;
      r = 40'd0;
      r[39:32] = 8'(exp_q.size());
      foreach (exp_q[i]) if (i < 4) r[i*8 +: 8] = exp_q[i];
      return r;
   endfunction

   // ---------------- stimulus primitives ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Present one command for a cycle; afterwards scramble the inputs.
   task automatic issue_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                            input logic [7:0] b, input logic [3:0] f);
      tx_log.delete();
      model_frame(t, a, d, b, f);
      CMD_TYPE = t; CMD_ADDR = a; CMD_DATA = d; CMD_OPB = b; CMD_FUN = f;
      CMD_VLD = 1'b1;
      step();
      CMD_VLD = 1'b0;
      CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom); CMD_DATA = 8'($urandom);
      CMD_OPB = 8'($urandom); CMD_FUN = 4'($urandom);
   endtask

   // Drive TX_RDY (0: always, 1: toggling, 2: random) until the frame is sent.
   task automatic run_frame(input int mode);
      for (int k = 0; k < 200; k++) begin
         if (tx_log.size() >= exp_q.size()) break;
         if (mode == 0) TX_RDY = 1'b1;
         else if (mode == 1) TX_RDY = (k % 2 == 1);
         else TX_RDY = 1'($urandom_range(0, 1));
         step();
      end
   endtask

   // Deliver n response bytes, each preceded by 'gap' idle cycles.
   task automatic drive_rsp(input int n, input logic [7:0] b0, input logic [7:0] b1, input int gap);
      for (int i = 0; i < n; i++) begin
         repeat (gap) step();
         RX_DATA = (i == 0) ? b0 : b1;
         RX_VLD = 1'b1;
         step();
         RX_VLD = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b0;
      repeat (2) step();
      n_total++; if (CMD_RDY !== 1'b1) $display("FAIL reset_cmd_rdy: got %b want 1", CMD_RDY); else n_pass++;
      n_total++; if (TX_VLD !== 1'b0) $display("FAIL reset_tx_vld: got %b want 0", TX_VLD); else n_pass++;
      n_total++; if (TX_DATA !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", TX_DATA); else n_pass++;
      n_total++; if ({RSP_VLD, RSP_TIMEOUT, BUSY} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {RSP_VLD, RSP_TIMEOUT, BUSY}); else n_pass++;
      n_total++; if (RSP_DATA !== 16'h0000) $display("FAIL reset_rsp_data: got %h want 0000", RSP_DATA); else n_pass++;
      RST = 1'b1;
      step();
   endtask

   task automatic test_write();
      TX_RDY = 1'b1;
      issue_cmd(2'd0, 4'd5, 8'h3C, 8'h77, 4'h9);
      n_total++; if ({TX_VLD, TX_DATA} !== {1'b1, 8'hAA}) $display("FAIL write_c1: got %b/%h want 1/aa", TX_VLD, TX_DATA); else n_pass++;
      n_total++; if ({BUSY, CMD_RDY} !== 2'b10) $display("FAIL write_busy: got %b want 10", {BUSY, CMD_RDY}); else n_pass++;
      step();
      n_total++; if ({TX_VLD, TX_DATA} !== {1'b1, 8'h05}) $display("FAIL write_c2: got %b/%h want 1/05", TX_VLD, TX_DATA); else n_pass++;
      step();
      n_total++; if ({TX_VLD, TX_DATA} !== {1'b1, 8'h3C}) $display("FAIL write_c3: got %b/%h want 1/3c", TX_VLD, TX_DATA); else n_pass++;
      step();
      n_total++; if ({TX_VLD, RSP_VLD, CMD_RDY, BUSY} !== 4'b0110) $display("FAIL write_c4: got %b want 0110", {TX_VLD, RSP_VLD, CMD_RDY, BUSY}); else n_pass++;
      n_total++; if (RSP_DATA !== 16'h0000) $display("FAIL write_rsp_data: got %h want 0000", RSP_DATA); else n_pass++;
      last_rsp = 16'h0000;
      step();
      n_total++; if (RSP_VLD !== 1'b0) $display("FAIL write_rsp_pulse: got %b want 0", RSP_VLD); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] d2;
      TX_RDY = 1'b1;
      issue_cmd(2'd0, 4'($urandom), 8'($urandom), 8'h00, 4'h0);
      run_frame(0);
      n_total++; if (RSP_VLD !== 1'b1 || CMD_RDY !== 1'b1) $display("FAIL b2b_first_done: got %b%b want 11", RSP_VLD, CMD_RDY); else n_pass++;
      d2 = 8'($urandom);
      issue_cmd(2'd0, 4'hF, d2, 8'h00, 4'h0);
      n_total++; if ({TX_VLD, TX_DATA} !== {1'b1, 8'hAA}) $display("FAIL b2b_second_start: got %b/%h want 1/aa", TX_VLD, TX_DATA); else n_pass++;
      run_frame(0);
      n_total++; if (pack_log() !== pack_exp()) $display("FAIL b2b_frame: got %h want %h", pack_log(), pack_exp()); else n_pass++;
      last_rsp = 16'h0000;
      step();
   endtask

   task automatic test_read();
      issue_cmd(2'd1, 4'd2, 8'($urandom), 8'($urandom), 4'($urandom));
      hold_viol = 0;
      run_frame(1);
      n_total++; if (pack_log() !== pack_exp()) $display("FAIL read_frame: got %h want %h", pack_log(), pack_exp()); else n_pass++;
      n_total++; if (hold_viol !== 0) $display("FAIL read_hold: got %0d violations want 0", hold_viol); else n_pass++;
      n_total++; if (TX_VLD !== 1'b0 || BUSY !== 1'b1) $display("FAIL read_after_frame: got vld %b busy %b want 0 1", TX_VLD, BUSY); else n_pass++;
      TX_RDY = 1'b1;
      drive_rsp(1, 8'h81, 8'h00, 3);
      last_rsp = model_rsp(2'd1, 8'h81, 8'h00);
      n_total++; if (RSP_VLD !== 1'b1 || RSP_DATA !== last_rsp) $display("FAIL read_rsp: got %b/%h want 1/%h", RSP_VLD, RSP_DATA, last_rsp); else n_pass++;
      step();
   endtask

   task automatic test_alu_ops();
      int t0;
      t0 = tmo_cnt;
      TX_RDY = 1'b1;
      issue_cmd(2'd2, 4'($urandom), 8'h12, 8'h34, 4'h0);
      run_frame(0);
      n_total++; if (pack_log() !== pack_exp()) $display("FAIL alu_frame: got %h want %h", pack_log(), pack_exp()); else n_pass++;
      drive_rsp(1, 8'h46, 8'h00, 0);
      drive_rsp(1, 8'h00, 8'h00, 50);
      last_rsp = model_rsp(2'd2, 8'h46, 8'h00);
      n_total++; if (RSP_VLD !== 1'b1 || RSP_DATA !== last_rsp) $display("FAIL alu_rsp: got %b/%h want 1/%h", RSP_VLD, RSP_DATA, last_rsp); else n_pass++;
      n_total++; if (tmo_cnt !== t0) $display("FAIL alu_no_timeout: got %0d timeouts want %0d", tmo_cnt, t0); else n_pass++;
      step();
   endtask

   task automatic test_alu_timeout();
      logic early;
      int   r0;
      early = 1'b0;
      r0 = rsp_cnt;
      TX_RDY = 1'b1;
      issue_cmd(2'd3, 4'($urandom), 8'($urandom), 8'($urandom), 4'h2);
      run_frame(0);
      n_total++; if (pack_log() !== pack_exp()) $display("FAIL nop_frame: got %h want %h", pack_log(), pack_exp()); else n_pass++;
      drive_rsp(1, 8'($urandom), 8'h00, 0);
      for (int j = 0; j < T; j++) begin
         if (RSP_TIMEOUT || RSP_VLD) early = 1'b1;
         step();
      end
      n_total++; if (early !== 1'b0) $display("FAIL tmo_early: got early pulse %b want 0", early); else n_pass++;
      n_total++; if ({RSP_TIMEOUT, RSP_VLD, CMD_RDY, BUSY} !== 4'b1010) $display("FAIL tmo_pulse: got %b want 1010", {RSP_TIMEOUT, RSP_VLD, CMD_RDY, BUSY}); else n_pass++;
      n_total++; if (RSP_DATA !== last_rsp) $display("FAIL tmo_rsp_data: got %h want %h", RSP_DATA, last_rsp); else n_pass++;
      step();
      n_total++; if (RSP_TIMEOUT !== 1'b0) $display("FAIL tmo_one_cycle: got %b want 0", RSP_TIMEOUT); else n_pass++;
      n_total++; if (rsp_cnt !== r0) $display("FAIL tmo_no_rsp_vld: got %0d want %0d", rsp_cnt, r0); else n_pass++;
   endtask

   task automatic test_expiry_race();
      logic [7:0] b;
      b = 8'($urandom);
      TX_RDY = 1'b1;
      issue_cmd(2'd1, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
      run_frame(0);
      repeat (T - 1) step();
      RX_DATA = b;
      RX_VLD = 1'b1;
      step();
      RX_VLD = 1'b0;
      last_rsp = model_rsp(2'd1, b, 8'h00);
      n_total++; if ({RSP_VLD, RSP_TIMEOUT} !== 2'b10) $display("FAIL race_winner: got %b want 10", {RSP_VLD, RSP_TIMEOUT}); else n_pass++;
      n_total++; if (RSP_DATA !== last_rsp) $display("FAIL race_data: got %h want %h", RSP_DATA, last_rsp); else n_pass++;
      step();
   endtask

   task automatic test_stray();
      logic [7:0] b0, b1;
      int         r0;
      r0 = rsp_cnt;
      for (int i = 0; i < 3; i++) begin
         RX_DATA = 8'($urandom); RX_VLD = 1'b1; step(); RX_VLD = 1'b0; step();
      end
      n_total++; if ({RSP_VLD, BUSY, CMD_RDY} !== 3'b001 || RSP_DATA !== last_rsp) $display("FAIL stray_idle: got %b/%h want 001/%h", {RSP_VLD, BUSY, CMD_RDY}, RSP_DATA, last_rsp); else n_pass++;
      TX_RDY = 1'b0;
      issue_cmd(2'd3, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
      RX_DATA = 8'($urandom); RX_VLD = 1'b1; step();
      RX_VLD = 1'b0; step();
      RX_DATA = 8'($urandom); RX_VLD = 1'b1; step();
      RX_VLD = 1'b0;
      run_frame(0);
      n_total++; if (pack_log() !== pack_exp()) $display("FAIL stray_frame: got %h want %h", pack_log(), pack_exp()); else n_pass++;
      b0 = 8'($urandom); b1 = 8'($urandom);
      drive_rsp(2, b0, b1, 2);
      last_rsp = model_rsp(2'd3, b0, b1);
      n_total++; if (RSP_VLD !== 1'b1 || RSP_DATA !== last_rsp) $display("FAIL stray_rsp: got %b/%h want 1/%h", RSP_VLD, RSP_DATA, last_rsp); else n_pass++;
      RX_DATA = ~b0; RX_VLD = 1'b1; step(); RX_VLD = 1'b0;
      repeat (3) step();
      n_total++; if (RSP_DATA !== last_rsp) $display("FAIL stray_third: got %h want %h", RSP_DATA, last_rsp); else n_pass++;
      n_total++; if (rsp_cnt !== r0 + 1) $display("FAIL stray_rsp_count: got %0d want %0d", rsp_cnt, r0 + 1); else n_pass++;
   endtask

   task automatic test_reset_mid_send();
      logic [7:0] opb;
      opb = 8'($urandom);
      TX_RDY = 1'b1;
      issue_cmd(2'd2, 4'($urandom), 8'($urandom), opb, 4'($urandom));
      step();
      step();
      n_total++; if ({TX_VLD, TX_DATA} !== {1'b1, opb}) $display("FAIL rst_mid_byte2: got %b/%h want 1/%h", TX_VLD, TX_DATA, opb); else n_pass++;
      #2;
      RST = 1'b0;
      #1;
      n_total++; if ({TX_VLD, CMD_RDY, RSP_VLD, BUSY} !== 4'b0100) $display("FAIL rst_mid_outputs: got %b want 0100", {TX_VLD, CMD_RDY, RSP_VLD, BUSY}); else n_pass++;
      step();
      RST = 1'b1;
      last_rsp = 16'h0000;
      step();
      issue_cmd(2'd2, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
      run_frame(0);
      n_total++; if (pack_log() !== pack_exp()) $display("FAIL rst_restart_frame: got %h want %h", pack_log(), pack_exp()); else n_pass++;
      drive_rsp(2, 8'h01, 8'h02, 0);
      last_rsp = 16'h0201;
      n_total++; if (RSP_DATA !== last_rsp) $display("FAIL rst_restart_rsp: got %h want %h", RSP_DATA, last_rsp); else n_pass++;
      step();
   endtask

   task automatic test_random();
      logic [1:0]  t;
      logic [7:0]  b0, b1;
      logic [15:0] want;
      for (int it = 0; it < 25; it++) begin
         t = 2'($urandom);
         hold_viol = 0;
         issue_cmd(t, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
         run_frame(2);
         n_total++; if (pack_log() !== pack_exp() || hold_viol !== 0) $display("FAIL rand_frame[%0d]: got %h hold %0d want %h hold 0", it, pack_log(), hold_viol, pack_exp()); else n_pass++;
         b0 = 8'($urandom); b1 = 8'($urandom);
         drive_rsp(model_rsp_len(t), b0, b1, $urandom_range(0, 8));
         want = model_rsp(t, b0, b1);
         n_total++; if (RSP_VLD !== 1'b1 || RSP_DATA !== want) $display("FAIL rand_rsp[%0d]: got %b/%h want 1/%h", it, RSP_VLD, RSP_DATA, want); else n_pass++;
         last_rsp = want;
         repeat ($urandom_range(0, 2)) step();
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_back_to_back();
      test_read();
      test_alu_ops();
      test_alu_timeout();
      test_expiry_race();
      test_stray();
      test_reset_mid_send();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
